instruction_fetch_unit: RTL

Front-end fetch stage of the single-cycle RISC-V core. It owns the program counter and drives the byte address into the combinational-read instruction memory. It captures each returned word with its PC into a small prefetch FIFO and hands {pc, instr} to decode over a valid/ready handshake. Branch/jump redirects flush the FIFO and reload the PC.

---
 rtl/instruction_fetch_unit.sv | 67 ++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, fetches from combinational imem and queues {pc, instr} for decode.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] PC_STEP    = 32'd4,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        misalign_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q [FIFO_DEPTH];
  logic [31:0]   pcs_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic          pop, push;
  assign imem_addr    = pc_q;
  assign if_valid     = count_q != '0;
  assign if_instr     = instr_q[rd_q];
  assign if_pc        = pcs_q[rd_q];
  assign misalign_err = err_q;
  assign pop  = if_valid & if_ready;
  assign push = fetch_en & ~redirect_valid & ((count_q != CW'(FIFO_DEPTH)) | pop);
  // A redirect discards the whole queue and any handshake in the same cycle.
  always_comb begin
    pc_d    = redirect_valid ? {redirect_pc[31:2], 2'b00} : push ? pc_q + PC_STEP : pc_q;
    count_d = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
    rd_d    = redirect_valid ? '0 : rd_q + AW'(pop);
    wr_d    = redirect_valid ? '0 : wr_q + AW'(push);
    err_d   = err_q | (redirect_valid & |redirect_pc[1:0]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_q[i] <= '0;
        pcs_q[i]   <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      err_q   <= err_d;
      if (push) begin
        instr_q[wr_q] <= imem_rdata;
        pcs_q[wr_q]   <= pc_q;
      end
    end
  end
endmodule
